muldiv_unit: RTL

Parametrised multiply/divide unit that owns the HI/LO architectural registers and serves the execute stage through a valid/ready request port. It generalises the fixed 3-stage multiplier and separate divider into one block with configurable operand width and multiplier latency. It adds accumulate modes (MADD/MSUB), a GPR-destination multiply (MUL) with a result strobe, and a defined flush/cancel. One operation is in flight at a time; the execute stage stalls on `req_ready`.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the HI/LO registers.
// One operation in flight; pipelined multiplier, restoring radix-2 divider.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data
);

  typedef enum logic [2:0] {
    OP_MULT = 3'd0,
    OP_DIV  = 3'd1,
    OP_MADD = 3'd2,
    OP_MSUB = 3'd3,
    OP_MTHI = 3'd4,
    OP_MTLO = 3'd5,
    OP_MUL  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  localparam int PW      = 2 * WIDTH;
  localparam int CNT_MAX = (MUL_STAGES > WIDTH + 1) ? MUL_STAGES : WIDTH + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  op_e             op_q;
  op_e             req_op_e;
  logic            accept;

  assign req_op_e  = op_e'(req_op);
  assign req_ready = (state == S_IDLE);
  assign busy      = !req_ready;
  assign accept    = req_ready && req_valid && !flush;

  // Multiplier datapath: operands extended by one bit so signed and unsigned share one signed multiply.
  logic                    mul_sgn;
  logic signed [WIDTH:0]   op_a_q, op_b_q;
  logic signed [PW-1:0]    a_ext, b_ext;
  logic [PW-1:0]           prod_now, prod_final;

  assign mul_sgn  = req_signed || (req_op_e == OP_MUL);
  assign a_ext    = PW'(op_a_q);
  assign b_ext    = PW'(op_b_q);
  assign prod_now = a_ext * b_ext;

  generate
    if (MUL_STAGES == 1) begin : g_comb
      assign prod_final = prod_now;
    end else begin : g_pipe
      logic [PW-1:0] pipe [MUL_STAGES-1];
      // NOTE: pipeline registers carry no reset; their contents are only consumed when the FSM says they are valid.
      always_ff @(posedge clk) begin
        pipe[0] <= prod_now;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign prod_final = pipe[MUL_STAGES-2];
    end
  endgenerate

  // Divider datapath: magnitudes are taken at accept so the iterations run unsigned.
  logic [WIDTH-1:0] div_rem, div_quo, div_dsr;
  logic             div_neg_q, div_neg_r, div_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign a_neg   = req_signed && req_a[WIDTH-1];
  assign b_neg   = req_signed && req_b[WIDTH-1];
  assign mag_a   = a_neg ? -req_a : req_a;
  assign mag_b   = b_neg ? -req_b : req_b;
  assign trial   = {1'b0, div_rem, div_quo[WIDTH-1]} - {2'b00, div_dsr};
  assign quo_fix = div_neg_q ? -div_quo : div_quo;
  assign rem_fix = div_neg_r ? -div_rem : div_rem;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q    <= {mul_sgn && req_a[WIDTH-1], req_a};
      op_b_q    <= {mul_sgn && req_b[WIDTH-1], req_b};
      div_quo   <= mag_a;
      div_dsr   <= mag_b;
      div_rem   <= '0;
      div_neg_q <= a_neg ^ b_neg;
      div_neg_r <= a_neg;
      div_zero  <= (req_b == '0);
    end else if (state == S_DIV && cnt > CW'(1)) begin
      if (!trial[WIDTH+1]) begin
        div_rem <= trial[WIDTH-1:0];
        div_quo <= {div_quo[WIDTH-2:0], 1'b1};
      end else begin
        div_rem <= {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
        div_quo <= {div_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Control FSM and architectural state.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= OP_NOP;
      hi        <= '0;
      lo        <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= req_op_e;
            unique case (req_op_e)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_MULT, OP_MADD, OP_MSUB, OP_MUL: begin
                state <= S_MUL;
                cnt   <= CW'(MUL_STAGES);
              end
              OP_DIV: begin
                state <= S_DIV;
                cnt   <= CW'(WIDTH + 1);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
            unique case (op_q)
              OP_MADD: {hi, lo} <= {hi, lo} + prod_final;
              OP_MSUB: {hi, lo} <= {hi, lo} - prod_final;
              OP_MUL: begin
                res_data  <= prod_final[WIDTH-1:0];
                res_valid <= 1'b1;
              end
              default: {hi, lo} <= prod_final;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
            // Most-negative / -1 falls out naturally: the magnitude quotient wraps to the same bit pattern.
            if (div_zero) begin
              lo <= '1;
              hi <= op_a_q[WIDTH-1:0];
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
